// File: rtl/win_trap_ctrl.sv
// Trap/tag controller: decodes issued ops into tag, window and trap-instruction events,
// tracks register-window occupancy and holds prioritised traps on a req/ack handshake.
module win_trap_ctrl #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NWIN   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [8:0]        in_op,
  input  logic [DATA_W-1:0] in_busA,
  input  logic [DATA_W-1:0] in_busB,
  input  logic              tag_en,
  input  logic [3:0]        trap_mask,
  output logic              out_valid,
  output logic              out_skip,
  output logic              trap_req,
  output logic [2:0]        trap_cause,
  output logic [2:0]        trap_code,
  input  logic              trap_ack,
  output logic [((NWIN > 1) ? $clog2(NWIN) : 1)-1:0] win_cnt
);

  localparam int CW = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam logic [CW-1:0] WIN_MAX = CW'(NWIN - 1);

  localparam logic [2:0] CL_CALL   = 3'b001;
  localparam logic [2:0] CL_RET    = 3'b010;
  localparam logic [2:0] CL_TRAPI  = 3'b011;
  localparam logic [2:0] CL_TAGCHK = 3'b100;
  localparam logic [2:0] CL_TAGCMP = 3'b101;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_TAG   = 3'd1;
  localparam logic [2:0] CAUSE_POV   = 3'd2;
  localparam logic [2:0] CAUSE_UNF   = 3'd3;
  localparam logic [2:0] CAUSE_TRAPI = 3'd4;

  typedef enum logic {ST_IDLE, ST_TRAP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cause_nxt, code_nxt, cause_sel;
  logic [CW-1:0]   win_nxt;
  logic            vld_p1_nxt, skip_p1_nxt;
  logic            vld_p1, skip_p1;

  // Window count moves by one and never wraps; masked POV/UNF rely on this saturation.
  function automatic logic [CW-1:0] win_step(input logic [CW-1:0] w,
                                             input logic up, input logic dn);
    if (up)      return (w == WIN_MAX) ? w : w + 1'b1;
    else if (dn) return (w == '0) ? w : w - 1'b1;
    else         return w;
  endfunction

  logic [2:0]       op_cls, op_code;
  logic [TAG_W-1:0] tag_a, tag_b;
  logic             is_call, is_ret, is_skip;
  logic             cond_tag, cond_pov, cond_unf, cond_trapi;
  logic             unused_bits;

  assign op_cls  = in_op[8:6];
  assign op_code = in_op[2:0];
  assign tag_a   = in_busA[DATA_W-1 -: TAG_W];
  assign tag_b   = in_busB[DATA_W-1 -: TAG_W];
  assign unused_bits = ^{in_op[5:3], in_busA[DATA_W-TAG_W-1:0], in_busB[DATA_W-TAG_W-1:0]};

  assign is_call = (op_cls == CL_CALL);
  assign is_ret  = (op_cls == CL_RET);
  assign is_skip = (op_cls == CL_TRAPI) && (op_code == 3'd0);

  assign cond_tag   = tag_en && (((op_cls == CL_TAGCHK) && (tag_a != '0)) ||
                                 ((op_cls == CL_TAGCMP) && (tag_a != tag_b)));
  assign cond_pov   = is_call && (win_cnt == WIN_MAX);
  assign cond_unf   = is_ret && (win_cnt == '0);
  assign cond_trapi = (op_cls == CL_TRAPI) && (op_code != 3'd0);

  // Classes are exclusive, so this chain selects at most one live cause.
  always_comb begin
    cause_sel = CAUSE_NONE;
    if (cond_tag && trap_mask[0])        cause_sel = CAUSE_TAG;
    else if (cond_pov && trap_mask[1])   cause_sel = CAUSE_POV;
    else if (cond_unf && trap_mask[2])   cause_sel = CAUSE_UNF;
    else if (cond_trapi && trap_mask[3]) cause_sel = CAUSE_TRAPI;
  end

  always_comb begin
    state_nxt   = state;
    cause_nxt   = trap_cause;
    code_nxt    = trap_code;
    win_nxt     = win_cnt;
    vld_p1_nxt  = 1'b0;
    skip_p1_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (cause_sel != CAUSE_NONE) begin
            state_nxt = ST_TRAP;
            cause_nxt = cause_sel;
            code_nxt  = (cause_sel == CAUSE_TRAPI) ? op_code : 3'd0;
          end else begin
            vld_p1_nxt  = 1'b1;
            skip_p1_nxt = is_skip;
            win_nxt     = win_step(win_cnt, is_call, is_ret);
          end
        end
      end
      ST_TRAP: begin
        if (trap_ack) begin
          state_nxt = ST_IDLE;
          cause_nxt = CAUSE_NONE;
          code_nxt  = 3'd0;
          // The handler spilled (POV) or filled (UNF) one window before acking.
          win_nxt   = win_step(win_cnt, trap_cause == CAUSE_UNF, trap_cause == CAUSE_POV);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: registered result of the issue edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      trap_cause <= CAUSE_NONE;
      trap_code  <= 3'd0;
      win_cnt    <= '0;
      vld_p1     <= 1'b0;
      skip_p1    <= 1'b0;
    end else begin
      state      <= state_nxt;
      trap_cause <= cause_nxt;
      trap_code  <= code_nxt;
      win_cnt    <= win_nxt;
      vld_p1     <= vld_p1_nxt;
      skip_p1    <= skip_p1_nxt;
    end
  end

  assign trap_req  = (state == ST_TRAP);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = vld_p1;
  assign out_skip  = skip_p1;

endmodule

// File: tb/tb_win_trap_ctrl.sv
// Bench for win_trap_ctrl: directed scenarios then randomized ops, all checked
// against a cycle-level behavioural model of window occupancy and trap handshake.
module tb_win_trap_ctrl;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int NWIN   = 8;
  localparam int CW     = $clog2(NWIN);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [8:0]        in_op = '0;
  logic [DATA_W-1:0] in_busA = '0;
  logic [DATA_W-1:0] in_busB = '0;
  logic              tag_en = 1'b0;
  logic [3:0]        trap_mask = 4'hF;
  logic              out_valid, out_skip, trap_req;
  logic [2:0]        trap_cause, trap_code;
  logic              trap_ack = 1'b0;
  logic [CW-1:0]     win_cnt;

  int tests = 0;
  int fails = 0;

  // model state
  int m_win = 0;
  bit m_req = 0;
  int m_cause = 0;
  int m_code = 0;
  bit m_ov = 0;
  bit m_sk = 0;

  win_trap_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NWIN(NWIN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_busA(in_busA), .in_busB(in_busB), .tag_en(tag_en),
    .trap_mask(trap_mask), .out_valid(out_valid), .out_skip(out_skip),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_code(trap_code),
    .trap_ack(trap_ack), .win_cnt(win_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] mkop(input int cls, input int code);
    logic [8:0] op;
    op = '0;
    op[8:6] = 3'(cls);
    op[2:0] = 3'(code);
    return op;
  endfunction

  // Model: what one clock edge does, given the inputs present before it.
  task automatic model_edge(input bit rn, input bit v, input logic [8:0] op,
                            input logic [31:0] a, input logic [31:0] b, input bit ten,
                            input logic [3:0] mask, input bit ack);
    int cls, code, ta, tb, cause;
    m_ov = 0;
    m_sk = 0;
    if (!rn) begin
      m_win = 0; m_req = 0; m_cause = 0; m_code = 0;
    end else if (m_req) begin
      if (ack) begin
        if (m_cause == 2) m_win = m_win - 1;
        if (m_cause == 3) m_win = m_win + 1;
        m_req = 0; m_cause = 0; m_code = 0;
      end
    end else if (v) begin
      cls  = int'(op[8:6]);
      code = int'(op[2:0]);
      ta   = int'(a[31:28]);
      tb   = int'(b[31:28]);
      cause = 0;
      if (ten && ((cls == 4 && ta != 0) || (cls == 5 && ta != tb)) && mask[0]) cause = 1;
      if (cls == 1 && m_win == NWIN - 1 && mask[1]) cause = 2;
      if (cls == 2 && m_win == 0 && mask[2]) cause = 3;
      if (cls == 3 && code != 0 && mask[3]) cause = 4;
      if (cause != 0) begin
        m_req = 1; m_cause = cause; m_code = (cause == 4) ? code : 0;
      end else begin
        m_ov = 1;
        m_sk = (cls == 3 && code == 0);
        if (cls == 1 && m_win < NWIN - 1) m_win = m_win + 1;
        if (cls == 2 && m_win > 0) m_win = m_win - 1;
      end
    end
  endtask

  task automatic step(input bit rn, input bit v, input logic [8:0] op,
                      input logic [31:0] a, input logic [31:0] b, input bit ten,
                      input logic [3:0] mask, input bit ack);
    rst_n = rn; in_valid = v; in_op = op; in_busA = a; in_busB = b;
    tag_en = ten; trap_mask = mask; trap_ack = ack;
    @(posedge clk);
    model_edge(rn, v, op, a, b, ten, mask, ack);
    #1;
    chk("trap_req",   int'(trap_req),   int'(m_req));
    chk("in_ready",   int'(in_ready),   int'(!m_req));
    chk("out_valid",  int'(out_valid),  int'(m_ov));
    chk("out_skip",   int'(out_skip),   int'(m_sk));
    chk("trap_cause", int'(trap_cause), m_cause);
    chk("trap_code",  int'(trap_code),  m_code);
    chk("win_cnt",    int'(win_cnt),    m_win);
  endtask

  task automatic op1(input logic [8:0] op, input logic [3:0] mask);
    step(1, 1, op, 32'h0, 32'h0, 0, mask, 0);
  endtask

  task automatic ack1();
    step(1, 0, 9'h0, 32'h0, 32'h0, 0, 4'hF, 1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int tags[3] = '{0, 3, 5};
    logic [3:0] rm;

    step(0, 1, mkop(1, 0), 0, 0, 0, 4'hF, 0);
    step(0, 0, 9'h0, 0, 0, 0, 4'hF, 0);
    chk("reset_win", int'(win_cnt), 0);
    chk("reset_req", int'(trap_req), 0);

    // Window overflow and spill on ack
    for (int i = 0; i < 7; i++) op1(mkop(1, 0), 4'hF);
    chk("seven_calls_win", int'(win_cnt), 7);
    op1(mkop(1, 0), 4'hF);
    chk("pov_cause", int'(trap_cause), 2);
    ack1();
    chk("pov_ack_win", int'(win_cnt), 6);
    chk("pov_ack_ready", int'(in_ready), 1);

    // Underflow and fill on ack
    step(0, 0, 9'h0, 0, 0, 0, 4'hF, 0);
    op1(mkop(2, 0), 4'hF);
    chk("unf_cause", int'(trap_cause), 3);
    ack1();
    chk("unf_ack_win", int'(win_cnt), 1);
    op1(mkop(2, 0), 4'hF);
    chk("ret_valid", int'(out_valid), 1);

    // Tag checks
    step(1, 1, mkop(5, 0), 32'h3123_4567, 32'h5abc_def0, 1, 4'hF, 0);
    chk("tagcmp_cause", int'(trap_cause), 1);
    ack1();
    step(1, 1, mkop(5, 0), 32'h3123_4567, 32'h5abc_def0, 0, 4'hF, 0);
    step(1, 1, mkop(4, 0), 32'h0fff_ffff, 32'h0, 1, 4'hF, 0);
    chk("tagchk_zero_valid", int'(out_valid), 1);

    // Trap instructions and skip
    op1(mkop(3, 0), 4'hF);
    chk("skip_pulse", int'(out_skip), 1);
    op1(mkop(3, 5), 4'hF);
    chk("trapi_code", int'(trap_code), 5);
    ack1();
    op1(mkop(3, 5), 4'h7);

    // Masked overflow, stall with in_valid high, held ack
    for (int i = 0; i < 7; i++) op1(mkop(1, 0), 4'hF);
    op1(mkop(1, 0), 4'hD);
    chk("masked_pov_win", int'(win_cnt), 7);
    op1(mkop(1, 0), 4'hF);
    for (int i = 0; i < 3; i++) op1(mkop(2, 0), 4'hF);
    chk("stall_win", int'(win_cnt), 7);
    for (int i = 0; i < 3; i++) ack1();
    chk("held_ack_win", int'(win_cnt), 6);

    // Reset during pending trap, then stray ack
    op1(mkop(1, 0), 4'hF);
    op1(mkop(1, 0), 4'hF);
    step(0, 0, 9'h0, 0, 0, 0, 4'hF, 0);
    chk("rst_trap_req", int'(trap_req), 0);
    ack1();
    chk("stray_ack_win", int'(win_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[31:28] = 4'(tags[$urandom_range(0, 2)]);
      rb[31:28] = 4'(tags[$urandom_range(0, 2)]);
      rm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      step(($urandom_range(0, 80) != 0), ($urandom_range(0, 4) != 0),
           mkop($urandom_range(0, 7), ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7)),
           ra, rb, $urandom_range(0, 1) == 1, rm, $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
